// File: rtl/prog_delay_line.sv
// prog_delay_line: delays a WIDTH-bit bus by a runtime-selectable 1..DEPTH enabled cycles
// Latency: d_act enabled edges from din sample to dout; outputs are registered
// Backpressure: none; en=0 freezes every register, so the line simply stalls
//
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   en        clock enable; disabled edges change nothing
//   din       input sample, written every enabled edge
//   dly       requested delay (0 -> 1, >DEPTH -> DEPTH)
//   dout      delayed data; dout_vld marks a full-delay sample
//   d_act     currently active (clamped) delay
//
// Optional macro PROG_DELAY_LINE_INERTIAL_EN: per-bit run counters suppress
// pulses shorter than d_act (inertial delay). Undefined: pure transport delay.

module prog_delay_line #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int DW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [DW-1:0]    dly,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [DW-1:0]    d_act
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {FILL, RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    d_act_q;
  logic [DW-1:0]    d_new;
  logic             dly_chg;
  logic             out_upd;
  logic             out_clr;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_nxt;
  logic             vld_q;

  logic [WIDTH-1:0] mem [DEPTH];

  // Clamp the requested delay into 1..DEPTH.
  always_comb begin
    d_new = dly;
    if (dly == '0)
      d_new = DW'(1);
    else if (dly > DW'(DEPTH))
      d_new = DW'(DEPTH);
  end

  // Truncation to AW bits makes d=DEPTH read the slot about to be overwritten;
  // the read happens before this edge's write lands, so the old value comes out.
  assign rd_ptr  = wr_ptr_q - d_act_q[AW-1:0];
  assign dly_chg = (d_new != d_act_q);

  // cnt_q counts samples written since entering FILL. Once it equals d, the
  // oldest needed sample is in the buffer and this edge can present it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_upd = 1'b0;
    out_clr = 1'b0;
    if (dly_chg) begin
      // The current edge's sample is the first one of the new fill.
      state_d = FILL;
      cnt_d   = DW'(1);
      out_clr = 1'b1;
    end else begin
      case (state_q)
        FILL: begin
          if (cnt_q == d_act_q) begin
            state_d = RUN;
            out_upd = 1'b1;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
        RUN:     out_upd = 1'b1;
        default: state_d = FILL;
      endcase
    end
  end

`ifdef PROG_DELAY_LINE_INERTIAL_EN
  logic [DW-1:0]    run_q [WIDTH];
  logic [WIDTH-1:0] last_q;

  // A bit only follows its input once the level has been stable for d samples;
  // shorter pulses never satisfy the threshold and dout holds.
  always_comb begin
    for (int b = 0; b < WIDTH; b++)
      dout_nxt[b] = (run_q[b] >= d_act_q) ? last_q[b] : dout_q[b];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      for (int b = 0; b < WIDTH; b++)
        run_q[b] <= '0;
    end else if (en) begin
      last_q <= din;
      for (int b = 0; b < WIDTH; b++) begin
        if (dly_chg || (din[b] != last_q[b]))
          run_q[b] <= DW'(1);  // restart: this edge's sample is run length 1
        else if (run_q[b] != DW'(DEPTH))
          run_q[b] <= run_q[b] + DW'(1);
      end
    end
  end
`else
  assign dout_nxt = mem[rd_ptr];
`endif

  // Buffer has no reset; stale contents are never presented because FILL
  // blocks output until d fresh samples have been written.
  always_ff @(posedge clk) begin
    if (en && !rst)
      mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      d_act_q  <= DW'(1);
      dout_q   <= '0;
      vld_q    <= 1'b0;
    end else if (en) begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_q + AW'(1);
      cnt_q    <= cnt_d;
      d_act_q  <= d_new;
      if (out_clr) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else if (out_upd) begin
        dout_q <= dout_nxt;
        vld_q  <= 1'b1;
      end
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign d_act    = d_act_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// tb_prog_delay_line: directed stimulus with hand-computed expectations for prog_delay_line
// Latency: inputs driven #1 after a rising edge, outputs checked #1 after the next edge
// Backpressure: n/a; en is toggled explicitly to stall the line

module tb_prog_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] din;
  logic [DW-1:0]    dly;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [DW-1:0]    d_act;

  int passed = 0;
  int total  = 0;

  prog_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .dly      (dly),
    .dout     (dout),
    .dout_vld (dout_vld),
    .d_act    (d_act)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [7:0] e;
    rst = 1'b1; en = 1'b0; din = '0; dly = DW'(1);
    tick(); tick();
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_dact", d_act, 1);

    // d=1 behaves as a single register once filled.
    rst = 1'b0; en = 1'b1; dly = DW'(1); din = 8'hA5;
    tick();
    chk("d1_vld_e0", dout_vld, 0);
    din = 8'h00;
    tick();
    chk("d1_dout_e1", dout, 8'hA5);
    chk("d1_vld_e1", dout_vld, 1);

    // d=5 ramp; the first edge is the delay change and counts as sample 1.
    for (int i = 0; i < 20; i++) begin
      dly = DW'(5); din = 8'(i);
      tick();
      if (i < 5) begin
        chk("d5_fill_vld", dout_vld, 0);
        chk("d5_fill_dout", dout, 0);
      end else begin
        chk("d5_vld", dout_vld, 1);
        chk("d5_dout", dout, i - 5);
      end
    end
    chk("d5_dact", d_act, 5);

    // d=DEPTH across several pointer wraps.
    for (int i = 0; i < 40; i++) begin
      dly = DW'(16); din = 8'(i);
      tick();
      if (i < 16) chk("d16_fill_vld", dout_vld, 0);
      else        chk("d16_dout", dout, i - 16);
    end
    dly = DW'(20); din = 8'd40;
    tick();
    chk("clamp_hi_dact", d_act, 16);
    chk("clamp_hi_vld", dout_vld, 1);
    chk("clamp_hi_dout", dout, 24);
    dly = DW'(0); din = 8'd41;
    tick();
    chk("clamp_lo_dact", d_act, 1);
    chk("clamp_lo_vld", dout_vld, 0);
    chk("clamp_lo_dout", dout, 0);

    // d=4 in RUN, then switch to 7 with an en-low gap mid-fill.
    for (int i = 0; i < 10; i++) begin
      dly = DW'(4); din = 8'h80 + 8'(i);
      tick();
      if (i >= 4) chk("d4_dout", dout, 8'h80 + i - 4);
    end
    for (int j = 0; j < 11; j++) begin
      if (j == 3) begin
        en = 1'b0; din = 8'hEE; dly = DW'(2);
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("en0_vld", dout_vld, 0);
          chk("en0_dact", d_act, 7);
        end
        en = 1'b1;
      end
      dly = DW'(7); din = 8'h90 + 8'(j);
      tick();
      if (j < 7) begin
        chk("d7_fill_vld", dout_vld, 0);
        chk("d7_fill_dout", dout, 0);
      end else begin
        chk("d7_vld", dout_vld, 1);
        chk("d7_dout", dout, 8'h90 + j - 7);
      end
    end

    // Reset in RUN with d=8, together with en=1 and a new dly.
    for (int i = 0; i < 10; i++) begin
      dly = DW'(8); din = 8'(i);
      tick();
      if (i >= 8) chk("d8_dout", dout, i - 8);
    end
    rst = 1'b1; en = 1'b1; dly = DW'(3); din = 8'h55;
    tick();
    chk("rstrun_dout", dout, 0);
    chk("rstrun_vld", dout_vld, 0);
    chk("rstrun_dact", d_act, 1);
    rst = 1'b0; dly = DW'(1); din = 8'h77;
    tick();
    chk("post_rst_vld0", dout_vld, 0);
    din = 8'h78;
    tick();
    chk("post_rst_dout", dout, 8'h77);
    chk("post_rst_vld1", dout_vld, 1);

    // Pulses on din[0] with d=4: 3-cycle then 4-cycle.
    for (int i = 0; i < 8; i++) begin
      dly = DW'(4); din = 8'h00;
      tick();
    end
    chk("pulse_pre_vld", dout_vld, 1);
    for (int len = 3; len <= 4; len++) begin
      for (int j = 0; j < 12; j++) begin
        din = (j < len) ? 8'h01 : 8'h00;
        tick();
        e = (j >= 4 && j < 4 + len) ? 8'h01 : 8'h00;
`ifdef PROG_DELAY_LINE_INERTIAL_EN
        if (len < 4) e = 8'h00;
`endif
        chk($sformatf("pulse%0d_j%0d", len, j), dout, e);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
